// File: rtl/logarithm.sv
// Natural-log unit: y (2.16 unsigned) -> x = ln(y) (0.16), shift-and-add greedy over a ln(1+2^-k) ROM.
// Build option: define LOGARITHM_ROUND_EN for round-half-up of the result (default truncates).
module logarithm #(
  parameter int ITER  = 17,
  parameter int GUARD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  intpart,
  input  logic [15:0] fracpart,
  output logic        done,
  output logic [15:0] x,
  output logic        err
);

  localparam int FW = 16 + GUARD;
  localparam int PW = FW + 3;
  localparam int AW = FW + 1;
  localparam int YW = FW + 2;
  localparam int KW = $clog2(ITER);
  localparam int ROM_SHL = (GUARD > 4) ? GUARD - 4 : 0;
  localparam int ROM_SHR = (GUARD < 4) ? 4 - GUARD : 0;

  localparam logic [PW-1:0] P_ONE  = {3'b001, {FW{1'b0}}};
  localparam logic [KW-1:0] K_LAST = KW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q;
  logic [YW-1:0] y_q;
  logic [PW-1:0] p_q, p_d, t_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [KW-1:0] k_q;
  logic          take_d;
  logic          done_q, err_q;
  logic [15:0]   x_q;

  // ln(1+2^-k) truncated at 2^-20, rescaled to the configured guard width
  function automatic logic [FW-1:0] ln_rom(input logic [KW-1:0] k);
    logic [31:0] v;
    case (int'(k))
      0:       v = 32'h000B1721;
      1:       v = 32'h00067CC8;
      2:       v = 32'h000391FE;
      3:       v = 32'h0001E270;
      4:       v = 32'h0000F851;
      5:       v = 32'h00007E0A;
      6:       v = 32'h00003F81;
      7:       v = 32'h00001FE0;
      8:       v = 32'h00000FF8;
      9:       v = 32'h000007FE;
      10:      v = 32'h000003FF;
      11:      v = 32'h000001FF;
      12:      v = 32'h000000FF;
      13:      v = 32'h0000007F;
      14:      v = 32'h0000003F;
      15:      v = 32'h0000001F;
      16:      v = 32'h0000000F;
      default: v = 32'h00000000;
    endcase
    v = (v << ROM_SHL) >> ROM_SHR;
    return v[FW-1:0];
  endfunction

  // Returns {err, x}: domain check, saturation, then 16-bit reduction of ACC
  function automatic logic [16:0] reduce(input logic [AW-1:0] acc, input logic [1:0] ip);
    logic [16:0] r;
    r = {1'b0, acc[FW-1:FW-16]};
`ifdef LOGARITHM_ROUND_EN
    r = r + {16'b0, acc[FW-17]};
`endif
    if (ip == 2'd0)
      return {1'b1, 16'h0000};
    else if (ip == 2'd3 || acc[FW] || r[16])
      return {1'b1, 16'hFFFF};
    else
      return {1'b0, r[15:0]};
  endfunction

  always_comb begin
    t_d    = p_q + (p_q >> k_q);
    take_d = (t_d <= {1'b0, y_q});
    p_d    = take_d ? t_d : p_q;
    acc_d  = take_d ? acc_q + {1'b0, ln_rom(k_q)} : acc_q;
  end

  // DONE also samples start so a held start yields results every ITER+1 cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      x_q     <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            y_q     <= {intpart, fracpart, {GUARD{1'b0}}};
            p_q     <= P_ONE;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          p_q   <= p_d;
          acc_q <= acc_d;
          k_q   <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            {err_q, x_q} <= reduce(acc_d, y_q[YW-1:FW]);
            done_q       <= 1'b1;
            state_q      <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done = done_q;
  assign x    = x_q;
  assign err  = err_q;

endmodule

// File: tb/tb_logarithm.sv
// Bench for logarithm: directed conversions, scoreboard of expected x ranges/err/latency per done pulse.
module tb_logarithm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  intpart = 2'd0;
  logic [15:0] fracpart = 16'h0000;
  logic        done;
  logic [15:0] x;
  logic        err;

  always #5 clk = ~clk;

  logarithm dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .intpart  (intpart),
    .fracpart (fracpart),
    .done     (done),
    .x        (x),
    .err      (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  string       q_tag[$];
  logic [15:0] q_lo[$];
  logic [15:0] q_hi[$];
  logic        q_err[$];
  int          q_e0[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                          input logic e, input int e0);
    q_tag.push_back(tag);
    q_lo.push_back(lo);
    q_hi.push_back(hi);
    q_err.push_back(e);
    q_e0.push_back(e0);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  string       m_tag;
  logic [15:0] m_lo, m_hi;
  logic        m_err;
  int          m_e0;
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      n_cmp++;
      assert (q_tag.size() != 0)
        else begin n_bad++; $error("FAIL unexpected_done: observed done=1 expected no pulse (x=%h)", x); end
      if (q_tag.size() != 0) begin
        m_tag = q_tag.pop_front();
        m_lo  = q_lo.pop_front();
        m_hi  = q_hi.pop_front();
        m_err = q_err.pop_front();
        m_e0  = q_e0.pop_front();
        n_cmp++;
        assert (((x >= m_lo) && (x <= m_hi)) === 1'b1)
          else begin n_bad++; $error("FAIL %s_x: observed %h expected %h..%h", m_tag, x, m_lo, m_hi); end
        n_cmp++;
        assert (err === m_err)
          else begin n_bad++; $error("FAIL %s_err: observed %b expected %b", m_tag, err, m_err); end
        n_cmp++;
        assert ((cyc - m_e0) == 17)
          else begin n_bad++; $error("FAIL %s_latency: observed %0d expected 17", m_tag, cyc - m_e0); end
      end
    end
  end

  task automatic wait_empty(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q_tag.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    n_cmp++;
    assert (q_tag.size() == 0)
      else begin n_bad++; $error("FAIL %s_timeout: observed %0d pending expected 0", tag, q_tag.size()); end
  endtask

  task automatic go(input string tag, input logic [1:0] ip, input logic [15:0] fp,
                    input logic [15:0] lo, input logic [15:0] hi, input logic e);
    @(negedge clk);
    intpart  = ip;
    fracpart = fp;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(tag, lo, hi, e, cyc);
    wait_empty(tag, 40);
  endtask

  task automatic go_model(input string tag, input logic [1:0] ip, input logic [15:0] fp);
    real y, xr;
    int  f, lo, hi;
    y  = real'(ip) + real'(fp) / 65536.0;
    xr = $ln(y) * 65536.0;
    f  = $rtoi(xr);
    lo = (f < 3) ? 0 : f - 3;
    hi = (f + 2 > 65535) ? 65535 : f + 2;
    go(tag, ip, fp, 16'(lo), 16'(hi), 1'b0);
  endtask

  initial begin
    #25;
    n_cmp++;
    assert (done === 1'b0) else begin n_bad++; $error("FAIL reset_done: observed %b expected 0", done); end
    n_cmp++;
    assert (x === 16'h0000) else begin n_bad++; $error("FAIL reset_x: observed %h expected 0000", x); end
    n_cmp++;
    assert (err === 1'b0) else begin n_bad++; $error("FAIL reset_err: observed %b expected 0", err); end
    #5 rst = 1'b1;

    go("y_1p0",  2'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    go("y_2p0",  2'd1 + 2'd1, 16'h0000, 16'hB171, 16'hB173, 1'b0);
    go("y_1p5",  2'd1, 16'h8000, 16'h67CC, 16'h67CD, 1'b0);
    go("round_trip", 2'd1, 16'hA612, 16'h7FFC, 16'h8004, 1'b0);
    go("below_one", 2'd0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
    go("int_three", 2'd3, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1);
    go_model("y_1p25", 2'd1, 16'h4000);
    go_model("y_1p1",  2'd1, 16'h199A);
    go_model("y_tiny", 2'd1, 16'h0007);
    go_model("y_2p5",  2'd2, 16'h8000);
    go_model("y_2p7",  2'd2, 16'hB333);
    go("above_e", 2'd2, 16'hC000, 16'hFFFF, 16'hFFFF, 1'b1);

    // Abort mid-conversion: outputs drop at once, nothing completes
    @(negedge clk);
    intpart = 2'd2; fracpart = 16'h0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    assert (done === 1'b0) else begin n_bad++; $error("FAIL abort_done: observed %b expected 0", done); end
    n_cmp++;
    assert (x === 16'h0000) else begin n_bad++; $error("FAIL abort_x: observed %h expected 0000", x); end
    n_cmp++;
    assert (err === 1'b0) else begin n_bad++; $error("FAIL abort_err: observed %b expected 0", err); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    go("after_abort", 2'd1, 16'h8000, 16'h67CC, 16'h67CD, 1'b0);

    // start held 3 cycles, inputs changed mid-way: one result on the latched y=2.0
    @(negedge clk);
    intpart = 2'd2; fracpart = 16'h0000; start = 1'b1;
    @(posedge clk);
    #1 push_exp("held_start", 16'hB171, 16'hB173, 1'b0, cyc);
    @(negedge clk);
    @(negedge clk);
    intpart = 2'd1; fracpart = 16'h8000;
    @(negedge clk);
    start = 1'b0;
    wait_empty("held_start", 40);
    repeat (5) @(negedge clk);

    // start held through DONE: two results 18 cycles apart
    @(negedge clk);
    intpart = 2'd1; fracpart = 16'h4000; start = 1'b1;
    @(posedge clk);
    #1;
    push_exp("b2b_first",  16'h391E, 16'h3920, 1'b0, cyc);
    push_exp("b2b_second", 16'h391E, 16'h3920, 1'b0, cyc + 18);
    repeat (18) @(posedge clk);
    #1 start = 1'b0;
    wait_empty("b2b", 60);
    repeat (25) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
